// File: rtl/alt_vipvfr130_common_pack_data.sv
// -----------------------------------------------------------------------------
// alt_vipvfr130_common_pack_data
//
// Packs a stream of narrow user-side words into wide memory-side words for the
// frame-writer master. Bits are packed continuously, LSB first, so a narrow
// word may straddle two wide words. A flush request emits any trailing partial
// word (zero-padded in the upper bits); clear synchronously discards all
// buffered data.
//
// Ports:
//   clock      in   single clock, all logic on the rising edge
//   reset      in   asynchronous active-low reset (0 = in reset)
//   data_in    in   [DATA_WIDTH_IN-1:0]  user-side word
//   write      in   data_in valid; accepted when write=1 and stall_out=0
//   stall_out  out  block cannot accept data_in this cycle
//   data_out   out  [DATA_WIDTH_OUT-1:0] packed memory-side word
//   write_out  out  data_out valid; consumed when write_out=1 and stall_in=0
//   stall_in   in   memory side cannot take data_out this cycle
//   flush      in   single-cycle request to emit a partial word
//   clear      in   synchronous discard of all buffered data
//   busy       out  accumulator / output register non-empty or flush pending
//   word_count out  [31:0] wide words consumed (only with the macro below)
//
// Optional feature macro: ALT_VIPVFR130_PACK_WORD_COUNT_EN
//   When defined, adds the word_count output, counting every consumed wide
//   word (including flushed partial words), reset to 0 and cleared by clear.
// -----------------------------------------------------------------------------
module alt_vipvfr130_common_pack_data #(
  parameter int DATA_WIDTH_IN  = 24,
  parameter int DATA_WIDTH_OUT = 128,
  parameter int FILL_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      write,
  output logic                      stall_out,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      write_out,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic                      clear,
  output logic                      busy
`ifdef ALT_VIPVFR130_PACK_WORD_COUNT_EN
  ,
  output logic [31:0]               word_count
`endif
);

  // The accumulator must hold a full wide word plus one more narrow word, so
  // an accept can land while a completed wide word is still waiting to move.
  localparam int ACC_W = DATA_WIDTH_OUT + DATA_WIDTH_IN;
  localparam logic [FILL_WIDTH-1:0] OUT_W = FILL_WIDTH'(DATA_WIDTH_OUT);
  localparam logic [FILL_WIDTH-1:0] IN_W  = FILL_WIDTH'(DATA_WIDTH_IN);

  // Registered state
  logic [ACC_W-1:0]          acc_reg,           acc_next;
  logic [FILL_WIDTH-1:0]     fill_reg,          fill_next;
  logic [DATA_WIDTH_OUT-1:0] out_reg,           out_next;
  logic                      out_valid_reg,     out_valid_next;
  logic                      flush_pending_reg, flush_pending_next;

  // Per-cycle decisions
  logic                      out_free;
  logic                      have_word;
  logic                      move;
  logic                      accept;
  logic                      flush_emit;
  logic [FILL_WIDTH-1:0]     fill_moved;
  logic [ACC_W-1:0]          acc_moved;
  logic [ACC_W-1:0]          data_shifted;
  logic [DATA_WIDTH_OUT-1:0] flush_mask;

  // Output slot can take a new word if empty or being consumed this cycle.
  assign out_free  = ~out_valid_reg | ~stall_in;
  assign have_word = (fill_reg >= OUT_W);
  assign move      = have_word & out_free;

  // Back-pressure: a completed word stuck in the accumulator, or any flush
  // activity, blocks new input. Held high while reset is asserted.
  assign stall_out = ~reset | (have_word & ~move) | flush_pending_reg | flush;
  assign accept    = write & ~stall_out;

  // A partial word is only emitted once every whole word has drained.
  assign flush_emit = flush_pending_reg & ~have_word & (fill_reg != '0) & out_free;

  // Position for the incoming word, accounting for a same-cycle move so that
  // move and accept together sustain one input word per cycle.
  assign fill_moved   = move ? (fill_reg - OUT_W) : fill_reg;
  assign acc_moved    = move ? (acc_reg >> DATA_WIDTH_OUT) : acc_reg;
  assign data_shifted = ACC_W'(data_in) << fill_moved;

  // Keeps only the valid low bits of a partial word; everything at or above
  // the fill level is forced to zero.
  for (genvar gi = 0; gi < DATA_WIDTH_OUT; gi++) begin : g_flush_mask
    assign flush_mask[gi] = (gi < int'(fill_reg));
  end

  always_comb begin
    acc_next           = acc_reg;
    fill_next          = fill_reg;
    out_next           = out_reg;
    out_valid_next     = out_valid_reg;
    flush_pending_next = flush_pending_reg;

    if (clear) begin
      // Clear beats everything, including a concurrent write or flush.
      acc_next           = '0;
      fill_next          = '0;
      out_next           = '0;
      out_valid_next     = 1'b0;
      flush_pending_next = 1'b0;
    end else begin
      // Output register
      if (move) begin
        out_next       = acc_reg[DATA_WIDTH_OUT-1:0];
        out_valid_next = 1'b1;
      end else if (flush_emit) begin
        out_next       = acc_reg[DATA_WIDTH_OUT-1:0] & flush_mask;
        out_valid_next = 1'b1;
      end else if (out_valid_reg & ~stall_in) begin
        out_valid_next = 1'b0;
      end

      // Accumulator and fill level
      acc_next  = acc_moved | (accept ? data_shifted : '0);
      fill_next = fill_moved + (accept ? IN_W : '0);

      // Flush completion: either the partial word went out, or there was
      // nothing left to emit.
      if (flush_emit) begin
        acc_next           = '0;
        fill_next          = '0;
        flush_pending_next = 1'b0;
      end else if (flush_pending_reg & (fill_reg == '0)) begin
        flush_pending_next = 1'b0;
      end

      // A new flush request is recorded last so it is never lost.
      if (flush) begin
        flush_pending_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_reg           <= '0;
      fill_reg          <= '0;
      out_reg           <= '0;
      out_valid_reg     <= 1'b0;
      flush_pending_reg <= 1'b0;
    end else begin
      acc_reg           <= acc_next;
      fill_reg          <= fill_next;
      out_reg           <= out_next;
      out_valid_reg     <= out_valid_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  assign data_out  = out_reg;
  assign write_out = out_valid_reg;
  assign busy      = (fill_reg != '0) | out_valid_reg | flush_pending_reg;

`ifdef ALT_VIPVFR130_PACK_WORD_COUNT_EN
  // Counts handshakes on the memory side; wraps naturally at 2^32.
  logic [31:0] word_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_count_reg <= '0;
    end else if (clear) begin
      word_count_reg <= '0;
    end else if (out_valid_reg & ~stall_in) begin
      word_count_reg <= word_count_reg + 32'd1;
    end
  end

  assign word_count = word_count_reg;
`endif

endmodule
